// File: rtl/gray_code_pipe_if.sv
// rtl/gray_code_pipe_if.sv - Input and output streams of the Gray/binary converter pipe.
interface gray_code_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_mode;
  logic             out_step_err;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_step_err
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_step_err
  );
endinterface

// File: rtl/gray_code_pipe.sv
// rtl/gray_code_pipe.sv - Pipelined bidirectional Gray/binary converter with Gray-step checker.
module gray_code_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input logic             clk,
  input logic             rst_n,
  gray_code_pipe_if.slave bus
);

  localparam logic [STAGES-1:0] ALL_STAGES = '1;
  localparam logic [WIDTH-1:0]  ONE        = WIDTH'(1);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] mode_q;
  logic [STAGES-1:0] err_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] mode_d;
  logic [STAGES-1:0] err_d;
  logic [WIDTH-1:0]  data_d [STAGES];

  logic [STAGES-1:0] advance;

  logic [WIDTH-1:0]  hist_q;
  logic [WIDTH-1:0]  hist_d;
  logic              hist_valid_q;
  logic              hist_valid_d;

  logic [WIDTH-1:0]  conv_data;
  logic [WIDTH-1:0]  step_diff;
  logic              step_err;
  logic              accept;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    conv_data = '0;
    if (bus.in_mode) begin
      conv_data = bus.in_data ^ (bus.in_data >> 1);
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        conv_data[i] = ^(bus.in_data >> i);
      end
    end
  end

  // x & (x-1) is non-zero exactly when x has two or more bits set.
  assign step_diff = bus.in_data ^ hist_q;
  assign step_err  = !bus.in_mode && hist_valid_q && (|(step_diff & (step_diff - ONE)));

  // Stage k moves when any stage from k to the end has a hole, or the sink takes a word.
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    assign advance[k] = bus.out_ready | ~(&(valid_q | ~(ALL_STAGES << k)));
  end

  assign accept = bus.in_valid && advance[0];

  always_comb begin
    hist_d       = hist_q;
    hist_valid_d = hist_valid_q;
    if (accept) begin
      if (bus.in_mode) begin
        hist_valid_d = 1'b0;
      end else begin
        hist_d       = bus.in_data;
        hist_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d    = '0;
    mode_d     = '0;
    err_d      = '0;
    valid_d[0] = bus.in_valid;
    mode_d[0]  = bus.in_mode;
    err_d[0]   = step_err;
    data_d[0]  = conv_data;
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      mode_d[k]  = mode_q[k-1];
      err_d[k]   = err_q[k-1];
      data_d[k]  = data_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      mode_q       <= '0;
      err_q        <= '0;
      hist_q       <= '0;
      hist_valid_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      hist_q       <= hist_d;
      hist_valid_q <= hist_valid_d;
      for (int k = 0; k < STAGES; k++) begin
        if (advance[k]) begin
          valid_q[k] <= valid_d[k];
          // Payload only moves with a real word so a drained stage keeps its last value.
          if (valid_d[k]) begin
            data_q[k] <= data_d[k];
            mode_q[k] <= mode_d[k];
            err_q[k]  <= err_d[k];
          end
        end
      end
    end
  end

  assign bus.in_ready     = advance[0];
  assign bus.out_valid    = valid_q[STAGES-1];
  assign bus.out_data     = data_q[STAGES-1];
  assign bus.out_mode     = mode_q[STAGES-1];
  assign bus.out_step_err = err_q[STAGES-1];

endmodule

// File: tb/tb_gray_code_pipe.sv
// tb/tb_gray_code_pipe.sv - Directed self-checking bench for gray_code_pipe.
module tb_gray_code_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gray_code_pipe_if #(.WIDTH(4)) b4 ();
  gray_code_pipe_if #(.WIDTH(8)) p1 ();
  gray_code_pipe_if #(.WIDTH(8)) p4 ();

  gray_code_pipe #(.WIDTH(4), .STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(b4));
  gray_code_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (.clk(clk), .rst_n(rst_n), .bus(p1));
  gray_code_pipe #(.WIDTH(8), .STAGES(4)) dut_s4 (.clk(clk), .rst_n(rst_n), .bus(p4));

  logic [3:0] q_data [$];
  logic       q_mode [$];
  logic       q_err  [$];
  int         q_cyc  [$];

  logic [7:0] cap1 [256];
  logic [7:0] cap4 [256];
  logic       ecap1 [256];
  logic       ecap4 [256];
  int         n1 = 0;
  int         n4 = 0;

  // Transfers are recorded on the falling edge ahead of the rising edge that completes them.
  always @(negedge clk) begin
    if (rst_n && b4.out_valid && b4.out_ready) begin
      q_data.push_back(b4.out_data);
      q_mode.push_back(b4.out_mode);
      q_err.push_back(b4.out_step_err);
      q_cyc.push_back(cyc);
    end
    if (rst_n && p1.out_valid && p1.out_ready) begin
      if (n1 < 256) begin
        cap1[n1]  = p1.out_data;
        ecap1[n1] = p1.out_step_err;
      end
      n1++;
    end
    if (rst_n && p4.out_valid && p4.out_ready) begin
      if (n4 < 256) begin
        cap4[n4]  = p4.out_data;
        ecap4[n4] = p4.out_step_err;
      end
      n4++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    b4.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_q();
    q_data.delete();
    q_mode.delete();
    q_err.delete();
    q_cyc.delete();
  endtask

  task automatic send4(input logic [3:0] d, input logic m);
    bit r;
    int guard;
    b4.in_valid = 1'b1;
    b4.in_data  = d;
    b4.in_mode  = m;
    guard = 0;
    do begin
      @(negedge clk);
      r = b4.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!r && guard < 50);
    b4.in_valid = 1'b0;
    n_cmp++;
    if (!r) begin
      n_err++;
      $display("FAIL send_timeout data=%b got accepted=0 want accepted=1", d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.in_mode = 1'b0; b4.out_ready = 1'b0;
    p1.in_valid = 1'b0; p1.in_data = '0; p1.in_mode = 1'b0; p1.out_ready = 1'b1;
    p4.in_valid = 1'b0; p4.in_data = '0; p4.in_mode = 1'b0; p4.out_ready = 1'b1;
    repeat (2) tick();
    n_cmp++; if (b4.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b want=0", b4.out_valid); end
    n_cmp++; if (b4.out_data !== 4'b0000) begin n_err++; $display("FAIL rst_out_data got=%b want=0000", b4.out_data); end
    n_cmp++; if (b4.out_mode !== 1'b0) begin n_err++; $display("FAIL rst_out_mode got=%b want=0", b4.out_mode); end
    n_cmp++; if (b4.out_step_err !== 1'b0) begin n_err++; $display("FAIL rst_step_err got=%b want=0", b4.out_step_err); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (b4.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b want=1", b4.in_ready); end
    n_cmp++; if (b4.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_idle_valid got=%b want=0", b4.out_valid); end
  endtask

  task automatic test_basic();
    clear_q();
    b4.out_ready = 1'b1;
    send4(4'b0110, 1'b0);
    n_cmp++; if (b4.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_early got=%b want=0", b4.out_valid); end
    tick();
    n_cmp++; if (b4.out_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid got=%b want=1", b4.out_valid); end
    n_cmp++; if (b4.out_data !== 4'b0100) begin n_err++; $display("FAIL g2b_0110 got=%b want=0100", b4.out_data); end
    n_cmp++; if (b4.out_mode !== 1'b0) begin n_err++; $display("FAIL g2b_mode got=%b want=0", b4.out_mode); end
    idle(2);
    send4(4'b1011, 1'b1);
    tick();
    n_cmp++; if (b4.out_data !== 4'b1110) begin n_err++; $display("FAIL b2g_1011 got=%b want=1110", b4.out_data); end
    n_cmp++; if (b4.out_mode !== 1'b1) begin n_err++; $display("FAIL b2g_mode got=%b want=1", b4.out_mode); end
    n_cmp++; if (b4.out_step_err !== 1'b0) begin n_err++; $display("FAIL b2g_err got=%b want=0", b4.out_step_err); end
    idle(3);
  endtask

  task automatic test_step();
    logic [3:0] in_g  [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0011, 4'b0000};
    logic [3:0] exp_d [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0000};
    logic       exp_e [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    clear_q();
    b4.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send4(in_g[i], 1'b0);
    idle(4);
    n_cmp++; if (q_data.size() != 5) begin n_err++; $display("FAIL step_count got=%0d want=5", q_data.size()); end
    for (int i = 0; i < 5 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== exp_d[i]) begin n_err++; $display("FAIL step_data[%0d] got=%b want=%b", i, q_data[i], exp_d[i]); end
      n_cmp++; if (q_err[i] !== exp_e[i]) begin n_err++; $display("FAIL step_err[%0d] got=%b want=%b", i, q_err[i], exp_e[i]); end
    end
    clear_q();
    send4(4'b0101, 1'b1);
    send4(4'b1111, 1'b0);
    idle(4);
    n_cmp++; if (q_data.size() != 2) begin n_err++; $display("FAIL clr_count got=%0d want=2", q_data.size()); end
    if (q_data.size() == 2) begin
      n_cmp++; if (q_data[0] !== 4'b0111) begin n_err++; $display("FAIL clr_b2g got=%b want=0111", q_data[0]); end
      n_cmp++; if (q_mode[0] !== 1'b1) begin n_err++; $display("FAIL clr_mode0 got=%b want=1", q_mode[0]); end
      n_cmp++; if (q_err[0] !== 1'b0) begin n_err++; $display("FAIL clr_err0 got=%b want=0", q_err[0]); end
      n_cmp++; if (q_data[1] !== 4'b1010) begin n_err++; $display("FAIL clr_g2b got=%b want=1010", q_data[1]); end
      n_cmp++; if (q_mode[1] !== 1'b0) begin n_err++; $display("FAIL clr_mode1 got=%b want=0", q_mode[1]); end
      n_cmp++; if (q_err[1] !== 1'b0) begin n_err++; $display("FAIL clr_err1 got=%b want=0", q_err[1]); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] words [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
    int idx = 0;
    int guard = 0;
    bit r;
    clear_q();
    b4.out_ready = 1'b0;
    repeat (5) begin
      b4.in_valid = 1'b1; b4.in_data = words[idx]; b4.in_mode = 1'b1;
      @(negedge clk); r = b4.in_ready;
      @(posedge clk); #1;
      if (r) idx++;
    end
    n_cmp++; if (idx != 2) begin n_err++; $display("FAIL bp_accepts got=%0d want=2", idx); end
    n_cmp++; if (b4.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b want=0", b4.in_ready); end
    n_cmp++; if (b4.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid got=%b want=1", b4.out_valid); end
    n_cmp++; if (b4.out_data !== 4'b0001) begin n_err++; $display("FAIL bp_hold_a got=%b want=0001", b4.out_data); end
    tick();
    n_cmp++; if (b4.out_data !== 4'b0001) begin n_err++; $display("FAIL bp_hold_b got=%b want=0001", b4.out_data); end
    b4.out_ready = 1'b1;
    #1;
    n_cmp++; if (b4.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_chain got=%b want=1", b4.in_ready); end
    while (idx < 5 && guard < 20) begin
      b4.in_valid = 1'b1; b4.in_data = words[idx]; b4.in_mode = 1'b1;
      @(negedge clk); r = b4.in_ready;
      @(posedge clk); #1;
      if (r) idx++;
      guard++;
    end
    n_cmp++; if (idx != 5) begin n_err++; $display("FAIL bp_all_accepted got=%0d want=5", idx); end
    idle(4);
    n_cmp++; if (q_data.size() != 5) begin n_err++; $display("FAIL bp_count got=%0d want=5", q_data.size()); end
    for (int i = 0; i < 5 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== exp_g[i]) begin n_err++; $display("FAIL bp_data[%0d] got=%b want=%b", i, q_data[i], exp_g[i]); end
      if (i > 0) begin
        n_cmp++; if (q_cyc[i] != q_cyc[i-1] + 1) begin n_err++; $display("FAIL bp_gap[%0d] got=%0d want=%0d", i, q_cyc[i], q_cyc[i-1] + 1); end
      end
    end
  endtask

  task automatic test_throughput();
    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    int acc = 0;
    int first_cyc = 0;
    bit r;
    clear_q();
    b4.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b4.in_valid = 1'b1; b4.in_data = 4'(i); b4.in_mode = 1'b1;
      @(negedge clk); r = b4.in_ready;
      @(posedge clk); #1;
      if (r) begin
        if (acc == 0) first_cyc = cyc;
        acc++;
      end
    end
    idle(4);
    n_cmp++; if (acc != 16) begin n_err++; $display("FAIL tp_accepts got=%0d want=16", acc); end
    n_cmp++; if (q_data.size() != 16) begin n_err++; $display("FAIL tp_count got=%0d want=16", q_data.size()); end
    for (int i = 0; i < 16 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== gtab[i]) begin n_err++; $display("FAIL tp_data[%0d] got=%b want=%b", i, q_data[i], gtab[i]); end
      n_cmp++; if (q_cyc[i] != first_cyc + 1 + i) begin n_err++; $display("FAIL tp_cycle[%0d] got=%0d want=%0d", i, q_cyc[i], first_cyc + 1 + i); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    b4.out_ready = 1'b0;
    send4(4'b0101, 1'b0);
    send4(4'b0100, 1'b0);
    n_cmp++; if (b4.out_valid !== 1'b1) begin n_err++; $display("FAIL rm_inflight got=%b want=1", b4.out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (b4.out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid_now got=%b want=0", b4.out_valid); end
    n_cmp++; if (b4.out_data !== 4'b0000) begin n_err++; $display("FAIL rm_data_now got=%b want=0000", b4.out_data); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (b4.in_ready !== 1'b1) begin n_err++; $display("FAIL rm_in_ready got=%b want=1", b4.in_ready); end
    b4.out_ready = 1'b1;
    send4(4'b1010, 1'b0);
    idle(4);
    n_cmp++; if (q_data.size() != 1) begin n_err++; $display("FAIL rm_count got=%0d want=1", q_data.size()); end
    if (q_data.size() == 1) begin
      n_cmp++; if (q_data[0] !== 4'b1100) begin n_err++; $display("FAIL rm_data got=%b want=1100", q_data[0]); end
      n_cmp++; if (q_err[0] !== 1'b0) begin n_err++; $display("FAIL rm_err got=%b want=0", q_err[0]); end
    end
  endtask

  task automatic test_param();
    logic [7:0] g1 [256];
    logic [7:0] g4 [256];
    logic [7:0] want;
    p1.out_ready = 1'b1; p4.out_ready = 1'b1;
    p1.in_valid = 1'b1; p1.in_data = 8'b10110011; p1.in_mode = 1'b0;
    p4.in_valid = 1'b1; p4.in_data = 8'b10110011; p4.in_mode = 1'b0;
    n_cmp++; if (p1.in_ready !== 1'b1) begin n_err++; $display("FAIL s1_ready got=%b want=1", p1.in_ready); end
    n_cmp++; if (p4.in_ready !== 1'b1) begin n_err++; $display("FAIL s4_ready got=%b want=1", p4.in_ready); end
    tick();
    p1.in_valid = 1'b0; p4.in_valid = 1'b0;
    n_cmp++; if (p1.out_valid !== 1'b1) begin n_err++; $display("FAIL s1_lat got=%b want=1", p1.out_valid); end
    n_cmp++; if (p1.out_data !== 8'b11011101) begin n_err++; $display("FAIL s1_data got=%b want=11011101", p1.out_data); end
    n_cmp++; if (p4.out_valid !== 1'b0) begin n_err++; $display("FAIL s4_e0 got=%b want=0", p4.out_valid); end
    tick();
    tick();
    n_cmp++; if (p4.out_valid !== 1'b0) begin n_err++; $display("FAIL s4_e2 got=%b want=0", p4.out_valid); end
    tick();
    n_cmp++; if (p4.out_valid !== 1'b1) begin n_err++; $display("FAIL s4_lat got=%b want=1", p4.out_valid); end
    n_cmp++; if (p4.out_data !== 8'b11011101) begin n_err++; $display("FAIL s4_data got=%b want=11011101", p4.out_data); end
    repeat (3) tick();

    n1 = 0; n4 = 0;
    for (int i = 0; i < 256; i++) begin
      p1.in_valid = 1'b1; p1.in_data = 8'(i); p1.in_mode = 1'b1;
      p4.in_valid = 1'b1; p4.in_data = 8'(i); p4.in_mode = 1'b1;
      tick();
    end
    p1.in_valid = 1'b0; p4.in_valid = 1'b0;
    repeat (6) tick();
    n_cmp++; if (n1 != 256) begin n_err++; $display("FAIL rt1_fwd_count got=%0d want=256", n1); end
    n_cmp++; if (n4 != 256) begin n_err++; $display("FAIL rt4_fwd_count got=%0d want=256", n4); end
    for (int i = 0; i < 256; i++) begin
      g1[i] = cap1[i];
      g4[i] = cap4[i];
      want = 8'(i) ^ (8'(i) >> 1);
      n_cmp++; if (g4[i] !== want) begin n_err++; $display("FAIL rt4_gray[%0d] got=%b want=%b", i, g4[i], want); end
    end
    n1 = 0; n4 = 0;
    for (int i = 0; i < 256; i++) begin
      p1.in_valid = 1'b1; p1.in_data = g1[i]; p1.in_mode = 1'b0;
      p4.in_valid = 1'b1; p4.in_data = g4[i]; p4.in_mode = 1'b0;
      tick();
    end
    p1.in_valid = 1'b0; p4.in_valid = 1'b0;
    repeat (6) tick();
    n_cmp++; if (n1 != 256) begin n_err++; $display("FAIL rt1_back_count got=%0d want=256", n1); end
    n_cmp++; if (n4 != 256) begin n_err++; $display("FAIL rt4_back_count got=%0d want=256", n4); end
    for (int i = 0; i < 256; i++) begin
      n_cmp++; if (cap1[i] !== 8'(i)) begin n_err++; $display("FAIL rt1_bin[%0d] got=%b want=%b", i, cap1[i], 8'(i)); end
      n_cmp++; if (cap4[i] !== 8'(i)) begin n_err++; $display("FAIL rt4_bin[%0d] got=%b want=%b", i, cap4[i], 8'(i)); end
      n_cmp++; if (ecap4[i] !== 1'b0) begin n_err++; $display("FAIL rt4_err[%0d] got=%b want=0", i, ecap4[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_step();
    test_backpressure();
    idle(3);
    test_throughput();
    test_reset_mid();
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
